// File: rtl/game_ctrl_if.sv
// Keyboard/finish inputs and registered game-state outputs of the game controller.
interface game_ctrl_if;
    logic [127:0] key_down;
    logic [8:0]   last_change;
    logic         key_valid;
    logic         finish;
    logic [1:0]   state;
    logic         mode;
    logic [6:0]   value;
    logic [1:0]   cd_digit;
    logic         start_pulse;

    modport master (
        output key_down, last_change, key_valid, finish,
        input  state, mode, value, cd_digit, start_pulse
    );

    modport slave (
        input  key_down, last_change, key_valid, finish,
        output state, mode, value, cd_digit, start_pulse
    );
endinterface

// File: rtl/game_ctrl.sv
// Typing-game front-end controller: mode/length selection, 3-2-1 countdown,
// in-game and finish states driven by keyboard press events.
module game_ctrl #(
    parameter int TICK = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    game_ctrl_if.slave  bus
);
    localparam int CNT_W = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK - 1);

    localparam logic [6:0] SC_TAB   = 7'd13;
    localparam logic [6:0] SC_MINUS = 7'd78;
    localparam logic [6:0] SC_EQUAL = 7'd85;
    localparam logic [6:0] SC_ENTER = 7'd90;
    localparam logic [6:0] SC_ESC   = 7'd118;

    typedef enum logic [1:0] {
        S_SELECT    = 2'd0,
        S_COUNTDOWN = 2'd1,
        S_INGAME    = 2'd2,
        S_FINISH    = 2'd3
    } state_t;

    state_t           state_reg;
    logic             mode_reg, mode_next;
    logic [1:0]       idx_reg, idx_next;
    logic [6:0]       value_reg;
    logic [1:0]       cd_digit_reg;
    logic             start_pulse_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [6:0] code;
    logic       press;
    logic       is_tab, is_minus, is_equal, is_enter, is_esc;

    // Only make events of the base (non-extended) code page count as presses.
    assign code     = bus.last_change[6:0];
    assign press    = bus.key_valid && (bus.last_change[8:7] == 2'b00) && bus.key_down[code];
    assign is_tab   = press && (code == SC_TAB);
    assign is_minus = press && (code == SC_MINUS);
    assign is_equal = press && (code == SC_EQUAL);
    assign is_enter = press && (code == SC_ENTER);
    assign is_esc   = press && (code == SC_ESC);

    function automatic logic [6:0] table_value(input logic m, input logic [1:0] i);
        logic [6:0] v;
        case ({m, i})
            3'b000:  v = 7'd15;
            3'b001:  v = 7'd30;
            3'b010:  v = 7'd60;
            3'b011:  v = 7'd120;
            3'b100:  v = 7'd10;
            3'b101:  v = 7'd25;
            3'b110:  v = 7'd50;
            default: v = 7'd100;
        endcase
        return v;
    endfunction

    always_comb begin
        mode_next = mode_reg;
        idx_next  = idx_reg;
        if (state_reg == S_SELECT) begin
            if (is_tab)
                mode_next = ~mode_reg;
            if (is_equal && idx_reg != 2'd3)
                idx_next = idx_reg + 2'd1;
            if (is_minus && idx_reg != 2'd0)
                idx_next = idx_reg - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= S_SELECT;
            mode_reg        <= 1'b0;
            idx_reg         <= 2'd0;
            value_reg       <= 7'd15;
            cd_digit_reg    <= 2'd0;
            start_pulse_reg <= 1'b0;
            cnt_reg         <= '0;
        end else begin
            mode_reg        <= mode_next;
            idx_reg         <= idx_next;
            value_reg       <= table_value(mode_next, idx_next);
            start_pulse_reg <= 1'b0;
            case (state_reg)
                S_SELECT: begin
                    if (is_enter) begin
                        state_reg    <= S_COUNTDOWN;
                        cnt_reg      <= '0;
                        cd_digit_reg <= 2'd3;
                    end
                end
                S_COUNTDOWN: begin
                    if (is_esc) begin
                        state_reg    <= S_SELECT;
                        cnt_reg      <= '0;
                        cd_digit_reg <= 2'd0;
                    end else if (cnt_reg == CNT_LAST) begin
                        cnt_reg <= '0;
                        if (cd_digit_reg == 2'd1) begin
                            state_reg       <= S_INGAME;
                            cd_digit_reg    <= 2'd0;
                            start_pulse_reg <= 1'b1;
                        end else begin
                            cd_digit_reg <= cd_digit_reg - 2'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_INGAME: begin
                    // Abort takes priority over a simultaneous game-over.
                    if (is_esc) begin
                        state_reg    <= S_SELECT;
                        cnt_reg      <= '0;
                        cd_digit_reg <= 2'd0;
                    end else if (bus.finish) begin
                        state_reg <= S_FINISH;
                    end
                end
                default: begin
                    if (is_enter || is_esc)
                        state_reg <= S_SELECT;
                end
            endcase
        end
    end

    assign bus.state       = state_reg;
    assign bus.mode        = mode_reg;
    assign bus.value       = value_reg;
    assign bus.cd_digit    = cd_digit_reg;
    assign bus.start_pulse = start_pulse_reg;
endmodule
